// File: rtl/reg_file_if.sv
// Issue, commit and operand-query bundle between the decoder/ROB side and the
// register file with rename tags.
interface reg_file_if;
  logic        rdy;
  logic        rollback;

  logic        issue;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_rob_pos;

  logic        reg_write;
  logic [4:0]  reg_rd;
  logic [31:0] reg_val;
  logic [3:0]  commit_rob_pos;

  logic [4:0]  rs1;
  logic        rs1_busy;
  logic [31:0] rs1_val;
  logic [3:0]  rs1_rob_pos;

  logic [4:0]  rs2;
  logic        rs2_busy;
  logic [31:0] rs2_val;
  logic [3:0]  rs2_rob_pos;

  modport master (
    output rdy, rollback,
    output issue, issue_rd, issue_rob_pos,
    output reg_write, reg_rd, reg_val, commit_rob_pos,
    output rs1, rs2,
    input  rs1_busy, rs1_val, rs1_rob_pos,
    input  rs2_busy, rs2_val, rs2_rob_pos
  );

  modport slave (
    input  rdy, rollback,
    input  issue, issue_rd, issue_rob_pos,
    input  reg_write, reg_rd, reg_val, commit_rob_pos,
    input  rs1, rs2,
    output rs1_busy, rs1_val, rs1_rob_pos,
    output rs2_busy, rs2_val, rs2_rob_pos
  );
endinterface

// File: rtl/reg_file.sv
// 32 x 32-bit architectural register file with per-register busy bit and ROB
// tag; operand queries see a same-cycle commit through a bypass.
module reg_file (
  input  logic       clk,
  input  logic       rst,
  reg_file_if.slave  rf
);
  localparam int NUM_REGS = 32;

  logic [31:0]         val_q [NUM_REGS];
  logic [31:0]         val_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [3:0]          tag_q [NUM_REGS];
  logic [3:0]          tag_d [NUM_REGS];

  logic commit_live;
  logic issue_live;

  assign commit_live = rf.reg_write && (rf.reg_rd != '0);
  assign issue_live  = rf.issue && (rf.issue_rd != '0);

  // NOTE: combinational blocks use blocking '=' so later statements see earlier
  // results within the same evaluation; every output gets its hold value first,
  // which is also what keeps this block from inferring latches.
  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rf.rdy) begin
      if (commit_live) begin
        val_d[rf.reg_rd] = rf.reg_val;
        if (busy_q[rf.reg_rd] && (tag_q[rf.reg_rd] == rf.commit_rob_pos)) begin
          busy_d[rf.reg_rd] = 1'b0;
        end
      end
      // Issue is evaluated after commit so it wins on a shared rd; rollback drops it.
      if (rf.rollback) begin
        busy_d = '0;
      end else if (issue_live) begin
        busy_d[rf.issue_rd] = 1'b1;
        tag_d[rf.issue_rd]  = rf.issue_rob_pos;
      end
    end
  end

  // NOTE: the storage arrays are reset here because software observes x-regs
  // as zero after reset; x0 is never written so it stays zero thereafter.
  // Sequential state always uses non-blocking '<='.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= '{default: '0};
      busy_q <= '0;
      tag_q  <= '{default: '0};
    end else begin
      val_q  <= val_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  always_comb begin
    rf.rs1_busy    = busy_q[rf.rs1];
    rf.rs1_val     = val_q[rf.rs1];
    rf.rs1_rob_pos = tag_q[rf.rs1];
    if (commit_live && (rf.reg_rd == rf.rs1) && busy_q[rf.rs1] &&
        (tag_q[rf.rs1] == rf.commit_rob_pos)) begin
      rf.rs1_busy = 1'b0;
      rf.rs1_val  = rf.reg_val;
    end
  end

  always_comb begin
    rf.rs2_busy    = busy_q[rf.rs2];
    rf.rs2_val     = val_q[rf.rs2];
    rf.rs2_rob_pos = tag_q[rf.rs2];
    if (commit_live && (rf.reg_rd == rf.rs2) && busy_q[rf.rs2] &&
        (tag_q[rf.rs2] == rf.commit_rob_pos)) begin
      rf.rs2_busy = 1'b0;
      rf.rs2_val  = rf.reg_val;
    end
  end
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by randomized
// traffic compared against an array-based model of the register state.
module tb_reg_file;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  reg_file_if bus ();

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .rf  (bus)
  );

  always #5 clk = ~clk;

  // Reference state: architectural value, pending flag and producing ROB slot.
  logic [31:0] m_val  [32];
  bit          m_busy [32];
  logic [3:0]  m_tag  [32];

  task automatic model_update();
    bit clr;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else if (bus.rdy) begin
      if (bus.reg_write && bus.reg_rd != 0) begin
        clr = m_busy[bus.reg_rd] && (m_tag[bus.reg_rd] == bus.commit_rob_pos);
        m_val[bus.reg_rd] = bus.reg_val;
        if (clr) m_busy[bus.reg_rd] = 1'b0;
      end
      if (bus.rollback) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (bus.issue && bus.issue_rd != 0) begin
        m_busy[bus.issue_rd] = 1'b1;
        m_tag[bus.issue_rd]  = bus.issue_rob_pos;
      end
    end
  endtask

  task automatic model_query(input logic [4:0] rs, output logic b, output logic [31:0] v,
                             output logic [3:0] p);
    b = m_busy[rs]; v = m_val[rs]; p = m_tag[rs];
    if (rs != 0 && bus.reg_write && bus.reg_rd == rs && m_busy[rs] &&
        m_tag[rs] == bus.commit_rob_pos) begin
      b = 1'b0; v = bus.reg_val;
    end
  endtask

  task automatic set_idle();
    rst = 1'b0;
    bus.rdy = 1'b1; bus.rollback = 1'b0;
    bus.issue = 1'b0; bus.issue_rd = '0; bus.issue_rob_pos = '0;
    bus.reg_write = 1'b0; bus.reg_rd = '0; bus.reg_val = '0; bus.commit_rob_pos = '0;
    bus.rs1 = '0; bus.rs2 = '0;
  endtask

  // Advance one clock: state moves at posedge, inputs change 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    bus.issue = 1'b1; bus.issue_rd = 5'd9; bus.issue_rob_pos = 4'd3;
    bus.reg_write = 1'b1; bus.reg_rd = 5'd9; bus.reg_val = 32'hCAFE_F00D;
    tick(); tick();
    set_idle();
    for (int i = 0; i < 32; i++) begin
      bus.rs1 = 5'(i); bus.rs2 = 5'(31 - i);
      #1;
      checks++;
      if (bus.rs1_busy !== 1'b0 || bus.rs1_val !== 32'd0 || bus.rs1_rob_pos !== 4'd0) begin
        errors++;
        $display("FAIL reset_rs1[%0d]: got busy=%b val=%h pos=%0d want 0/0/0", i,
                 bus.rs1_busy, bus.rs1_val, bus.rs1_rob_pos);
      end
      checks++;
      if (bus.rs2_busy !== 1'b0 || bus.rs2_val !== 32'd0 || bus.rs2_rob_pos !== 4'd0) begin
        errors++;
        $display("FAIL reset_rs2[%0d]: got busy=%b val=%h pos=%0d want 0/0/0", 31 - i,
                 bus.rs2_busy, bus.rs2_val, bus.rs2_rob_pos);
      end
    end
  endtask

  task automatic test_issue_commit();
    set_idle();
    bus.issue = 1'b1; bus.issue_rd = 5'd5; bus.issue_rob_pos = 4'd3;
    tick();
    set_idle(); bus.rs1 = 5'd5; #1;
    checks++;
    if (bus.rs1_busy !== 1'b1 || bus.rs1_rob_pos !== 4'd3) begin
      errors++;
      $display("FAIL issue_busy: got busy=%b pos=%0d want 1/3", bus.rs1_busy, bus.rs1_rob_pos);
    end
    bus.reg_write = 1'b1; bus.reg_rd = 5'd5; bus.commit_rob_pos = 4'd3; bus.reg_val = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (bus.rs1_busy !== 1'b0 || bus.rs1_val !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL commit_bypass: got busy=%b val=%h want 0/deadbeef", bus.rs1_busy, bus.rs1_val);
    end
    tick();
    set_idle(); bus.rs1 = 5'd5; #1;
    checks++;
    if (bus.rs1_busy !== 1'b0 || bus.rs1_val !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL commit_state: got busy=%b val=%h want 0/deadbeef", bus.rs1_busy, bus.rs1_val);
    end
  endtask

  task automatic test_tag_match();
    set_idle();
    bus.issue = 1'b1; bus.issue_rd = 5'd7; bus.issue_rob_pos = 4'd2; tick();
    bus.issue_rob_pos = 4'd9; tick();
    set_idle();
    bus.reg_write = 1'b1; bus.reg_rd = 5'd7; bus.commit_rob_pos = 4'd2; bus.reg_val = 32'h11;
    tick();
    set_idle(); bus.rs2 = 5'd7; #1;
    checks++;
    if (bus.rs2_busy !== 1'b1 || bus.rs2_rob_pos !== 4'd9 || bus.rs2_val !== 32'h11) begin
      errors++;
      $display("FAIL stale_commit: got busy=%b pos=%0d val=%h want 1/9/11", bus.rs2_busy,
               bus.rs2_rob_pos, bus.rs2_val);
    end
    bus.reg_write = 1'b1; bus.reg_rd = 5'd7; bus.commit_rob_pos = 4'd9; bus.reg_val = 32'h22;
    #1;
    checks++;
    if (bus.rs2_busy !== 1'b0 || bus.rs2_val !== 32'h22) begin
      errors++;
      $display("FAIL match_bypass: got busy=%b val=%h want 0/22", bus.rs2_busy, bus.rs2_val);
    end
    tick();
    set_idle(); bus.rs2 = 5'd7; #1;
    checks++;
    if (bus.rs2_busy !== 1'b0 || bus.rs2_val !== 32'h22) begin
      errors++;
      $display("FAIL match_state: got busy=%b val=%h want 0/22", bus.rs2_busy, bus.rs2_val);
    end
  endtask

  task automatic test_same_rd();
    set_idle();
    bus.issue = 1'b1; bus.issue_rd = 5'd4; bus.issue_rob_pos = 4'd1; tick();
    bus.issue_rob_pos = 4'd6;
    bus.reg_write = 1'b1; bus.reg_rd = 5'd4; bus.commit_rob_pos = 4'd1; bus.reg_val = 32'h55;
    tick();
    set_idle(); bus.rs1 = 5'd4; #1;
    checks++;
    if (bus.rs1_busy !== 1'b1 || bus.rs1_rob_pos !== 4'd6 || bus.rs1_val !== 32'h55) begin
      errors++;
      $display("FAIL issue_wins: got busy=%b pos=%0d val=%h want 1/6/55", bus.rs1_busy,
               bus.rs1_rob_pos, bus.rs1_val);
    end
  endtask

  task automatic test_x0();
    set_idle();
    bus.issue = 1'b1; bus.issue_rd = 5'd0; bus.issue_rob_pos = 4'd5;
    bus.reg_write = 1'b1; bus.reg_rd = 5'd0; bus.reg_val = 32'hFF;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    #1;
    checks++;
    if (bus.rs1_busy !== 1'b0 || bus.rs1_val !== 32'd0 || bus.rs1_rob_pos !== 4'd0) begin
      errors++;
      $display("FAIL x0_comb: got busy=%b val=%h pos=%0d want 0/0/0", bus.rs1_busy,
               bus.rs1_val, bus.rs1_rob_pos);
    end
    tick();
    set_idle(); #1;
    checks++;
    if (bus.rs2_busy !== 1'b0 || bus.rs2_val !== 32'd0 || bus.rs2_rob_pos !== 4'd0) begin
      errors++;
      $display("FAIL x0_state: got busy=%b val=%h pos=%0d want 0/0/0", bus.rs2_busy,
               bus.rs2_val, bus.rs2_rob_pos);
    end
  endtask

  task automatic test_rollback();
    logic [4:0] probe [4];
    probe = '{5'd1, 5'd2, 5'd3, 5'd8};
    set_idle();
    bus.issue = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      bus.issue_rd = 5'(r); bus.issue_rob_pos = 4'(r); tick();
    end
    set_idle();
    bus.rollback = 1'b1;
    bus.reg_write = 1'b1; bus.reg_rd = 5'd1; bus.commit_rob_pos = 4'd1; bus.reg_val = 32'hAA;
    bus.issue = 1'b1; bus.issue_rd = 5'd8; bus.issue_rob_pos = 4'd4;
    tick();
    set_idle();
    foreach (probe[k]) begin
      bus.rs1 = probe[k]; #1;
      checks++;
      if (bus.rs1_busy !== 1'b0) begin
        errors++;
        $display("FAIL rollback_busy x%0d: got %b want 0", probe[k], bus.rs1_busy);
      end
    end
    bus.rs2 = 5'd1; #1;
    checks++;
    if (bus.rs2_val !== 32'hAA) begin
      errors++;
      $display("FAIL rollback_write: got %h want aa", bus.rs2_val);
    end
  endtask

  task automatic test_rdy();
    set_idle();
    bus.issue = 1'b1; bus.issue_rd = 5'd6; bus.issue_rob_pos = 4'd7; tick();
    set_idle();
    bus.rdy = 1'b0;
    bus.issue = 1'b1; bus.issue_rd = 5'd6; bus.issue_rob_pos = 4'd2;
    bus.reg_write = 1'b1; bus.reg_rd = 5'd6; bus.commit_rob_pos = 4'd7; bus.reg_val = 32'h66;
    bus.rs1 = 5'd6; #1;
    checks++;
    if (bus.rs1_busy !== 1'b0 || bus.rs1_val !== 32'h66) begin
      errors++;
      $display("FAIL stall_bypass: got busy=%b val=%h want 0/66", bus.rs1_busy, bus.rs1_val);
    end
    tick(); tick();
    set_idle(); bus.rs1 = 5'd6; #1;
    checks++;
    if (bus.rs1_busy !== 1'b1 || bus.rs1_rob_pos !== 4'd7 || bus.rs1_val !== 32'd0) begin
      errors++;
      $display("FAIL stall_hold: got busy=%b pos=%0d val=%h want 1/7/0", bus.rs1_busy,
               bus.rs1_rob_pos, bus.rs1_val);
    end
    bus.reg_write = 1'b1; bus.reg_rd = 5'd6; bus.commit_rob_pos = 4'd7; bus.reg_val = 32'h66;
    tick();
    set_idle(); bus.rs1 = 5'd6; #1;
    checks++;
    if (bus.rs1_busy !== 1'b0 || bus.rs1_val !== 32'h66) begin
      errors++;
      $display("FAIL stall_resume: got busy=%b val=%h want 0/66", bus.rs1_busy, bus.rs1_val);
    end
  endtask

  task automatic test_random();
    logic        eb;
    logic [31:0] ev;
    logic [3:0]  ep;
    for (int n = 0; n < 600; n++) begin
      rst               = ($urandom_range(0, 63) == 0);
      bus.rdy           = ($urandom_range(0, 7) != 0);
      bus.rollback      = ($urandom_range(0, 15) == 0);
      bus.issue         = $urandom_range(0, 1);
      bus.issue_rd      = 5'($urandom_range(0, 7));
      bus.issue_rob_pos = 4'($urandom_range(0, 15));
      bus.reg_write     = $urandom_range(0, 1);
      bus.reg_rd        = 5'($urandom_range(0, 7));
      bus.reg_val       = $urandom;
      bus.commit_rob_pos = ($urandom_range(0, 1) == 1) ? m_tag[bus.reg_rd]
                                                       : 4'($urandom_range(0, 15));
      bus.rs1           = 5'($urandom_range(0, 7));
      bus.rs2           = 5'($urandom_range(0, 31));
      #1;
      model_query(bus.rs1, eb, ev, ep);
      checks++;
      if (bus.rs1_busy !== eb || bus.rs1_val !== ev || (eb && bus.rs1_rob_pos !== ep)) begin
        errors++;
        $display("FAIL rand_rs1 n=%0d x%0d: got busy=%b val=%h pos=%0d want %b/%h/%0d", n,
                 bus.rs1, bus.rs1_busy, bus.rs1_val, bus.rs1_rob_pos, eb, ev, ep);
      end
      model_query(bus.rs2, eb, ev, ep);
      checks++;
      if (bus.rs2_busy !== eb || bus.rs2_val !== ev || (eb && bus.rs2_rob_pos !== ep)) begin
        errors++;
        $display("FAIL rand_rs2 n=%0d x%0d: got busy=%b val=%h pos=%0d want %b/%h/%0d", n,
                 bus.rs2, bus.rs2_busy, bus.rs2_val, bus.rs2_rob_pos, eb, ev, ep);
      end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    set_idle();
    #1;
    test_reset();
    test_issue_commit();
    test_tag_match();
    test_same_rd();
    test_x0();
    test_rollback();
    test_rdy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameters (fixed, from macros): `REG_POS_WID` = 5 bits; `DATA_WID` = 32 bits; `ROB_POS_WID` = 4 bits (ROB_SIZE = 16).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset: clk and rst.
REQ-003 clk  in  1  system clock; all state updates on posedge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 rdy  in  1  global enable; low = hold all state.
REQ-006 rollback  in  1  ROB misprediction flush.
REQ-007 issue  in  1  decoder issues an instruction this cycle.
REQ-008 issue_rd  in  5  destination register of the issued instruction.
REQ-009 issue_rob_pos  in  4  ROB slot allocated to the issued instruction.
REQ-010 reg_write  in  1  ROB commits a register write this cycle.
REQ-011 reg_rd  in  5  committed destination register.
REQ-012 reg_val  in  32  committed value.
REQ-013 commit_rob_pos  in  4  ROB slot being committed.
REQ-014 rs1  in  5  source register 1 query.
REQ-015 rs1_busy  out  1  rs1 awaits an in-flight producer.
REQ-016 rs1_val  out  32  architectural value of rs1 (valid when !rs1_busy).
REQ-017 rs1_rob_pos  out  4  producing ROB slot (valid when rs1_busy).
REQ-018 rs2 / rs2_busy / rs2_val / rs2_rob_pos: same as REQ-014..017, for source 2.

Function
REQ-019 State: val[32] x 32 bits, busy[32] x 1 bit, tag[32] x 4 bits.
REQ-020 Register x0 SHALL read val=0, busy=0, rob_pos=0; writes and issues to x0 SHALL be ignored.
REQ-021 Commit (reg_write=1, reg_rd!=0): val[reg_rd] <= reg_val at the next edge.
REQ-022 Commit SHALL clear busy[reg_rd] only if busy[reg_rd]=1 and tag[reg_rd]==commit_rob_pos; otherwise busy and tag are unchanged.
REQ-023 Issue (issue=1, issue_rd!=0): busy[issue_rd] <= 1 and tag[issue_rd] <= issue_rob_pos at the next edge.
REQ-024 Issue and commit to the same rd in one cycle: the value write happens; busy=1 and tag=issue_rob_pos (the issue wins).
REQ-025 Rollback=1: every busy bit cleared at the next edge; tags are don't-care; a same-cycle reg_write value SHALL still be written; a same-cycle issue SHALL be discarded.
REQ-026 Queries are combinational (zero latency) from current state plus commit bypass.
REQ-027 Bypass: if reg_write=1, reg_rd==rsX!=0, busy[rsX]=1 and tag[rsX]==commit_rob_pos, then rsX_busy=0 and rsX_val=reg_val.
REQ-028 Otherwise: rsX_busy=busy[rsX], rsX_val=val[rsX], rsX_rob_pos=tag[rsX].
REQ-029 Same-cycle issue SHALL NOT bypass into queries; the decoder resolves intra-cycle rd/rs conflicts.
REQ-030 rdy=0 with rst=0: no state change; combinational outputs still track inputs.
REQ-031 Priority per edge: rst > !rdy > (rollback, commit, issue per REQ-021..025).

Reset
REQ-032 rst=1 at posedge: all val, busy and tag SHALL be set to 0, regardless of rdy, rollback, issue or reg_write.
REQ-033 After reset, every query SHALL return busy=0, val=0, rob_pos=0.
REQ-034 Reset asserted mid-operation SHALL discard any pending issue or commit of that cycle.

Verification
REQ-035 Reset, then issue rd=5 pos=3; next cycle query rs1=5 -> busy=1, rob_pos=3; commit rd=5 pos=3 val=0xDEADBEEF -> same-cycle rs1_busy=0, val=0xDEADBEEF; next cycle busy=0.
REQ-036 Issue rd=7 pos=2, then issue rd=7 pos=9; commit rd=7 pos=2 val=0x11 -> val[7]=0x11, busy=1, tag=9; commit pos=9 val=0x22 -> busy=0, val=0x22.
REQ-037 Same cycle: issue rd=4 pos=6 and commit rd=4 pos=1 (tag=1) val=0x55 -> val[4]=0x55, busy=1, tag=6.
REQ-038 Issue rd=0 pos=5 and commit rd=0 val=0xFF -> rs1=0 reads busy=0, val=0.
REQ-039 Busy x1, x2, x3; assert rollback with commit rd=1 val=0xAA and issue rd=8 -> all busy=0, val[1]=0xAA, x8 not busy.
REQ-040 rdy=0 with issue rd=6 and commit rd=6 -> no state change; raise rdy -> behaviour resumes.
